// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage with register file, load-use
// interlock and the ID/EX pipeline register.
package core_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4
  } wb_sel_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
endpackage

module id_ex_decode_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int BYPASS_EN  = 1,
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid_i,
  input  logic [31:0]               instruction_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      WB_RegWrite_i,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  output logic                      id_ready_o,
  output logic                      ex_valid_o,
  output logic [DATA_WIDTH-1:0]     ex_pc_o,
  output logic [DATA_WIDTH-1:0]     ex_immediate_o,
  output logic [DATA_WIDTH-1:0]     ex_rd_data1_o,
  output logic [DATA_WIDTH-1:0]     ex_rd_data2_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
  output logic [2:0]                ex_funct3_o,
  output logic                      ex_ALUSrcA_o,
  output logic                      ex_ALUSrcB_o,
  output logic                      ex_Branch_o,
  output logic                      ex_Jump_o,
  output logic                      ex_MemWrite_o,
  output logic                      ex_MemRead_o,
  output logic                      ex_RegWrite_o,
  output alu_op_e                   ex_ALUOp_o,
  output wb_sel_e                   ex_WBSel_o
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic                      src_a;
    logic                      src_b;
    logic                      branch;
    logic                      jump;
    logic                      mem_write;
    logic                      mem_read;
    logic                      reg_write;
    alu_op_e                   alu_op;
    wb_sel_e                   wb_sel;
  } id_ex_t;

  logic [DATA_WIDTH-1:0] rf [REG_COUNT];

  logic [6:0]                opc;
  logic [2:0]                f3;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] imm_u, imm_j, imm;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic uses_rs1, uses_rs2, hazard;
  id_ex_t dec, ex_q;

  assign opc = instruction_i[6:0];
  assign f3  = instruction_i[14:12];
  assign rs1 = instruction_i[15 +: REG_ADDR_WIDTH];
  assign rs2 = instruction_i[20 +: REG_ADDR_WIDTH];
  assign rd  = instruction_i[7 +: REG_ADDR_WIDTH];

  assign imm_i = {{20{instruction_i[31]}},
                  instruction_i[31:20]};
  assign imm_s = {{20{instruction_i[31]}},
                  instruction_i[31:25],
                  instruction_i[11:7]};
  assign imm_b = {{19{instruction_i[31]}},
                  instruction_i[31],
                  instruction_i[7],
                  instruction_i[30:25],
                  instruction_i[11:8], 1'b0};
  assign imm_u = {instruction_i[31:12], 12'b0};
  assign imm_j = {{11{instruction_i[31]}},
                  instruction_i[31],
                  instruction_i[19:12],
                  instruction_i[20],
                  instruction_i[30:21], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        rf[i] <= '0;
    end else if (WB_RegWrite_i && wr_addr_i != '0) begin
      rf[wr_addr_i] <= wr_data_i;
    end
  end

  // Bypass lets an operand see the write landing
  // on the same edge that captures it into ID/EX.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) begin
      rs1_data = rf[rs1];
      if (BYPASS_EN != 0 && WB_RegWrite_i &&
          wr_addr_i == rs1)
        rs1_data = wr_data_i;
    end
    if (rs2 != '0) begin
      rs2_data = rf[rs2];
      if (BYPASS_EN != 0 && WB_RegWrite_i &&
          wr_addr_i == rs2)
        rs2_data = wr_data_i;
    end
  end

  function automatic alu_op_e alu_sel(
    input logic [2:0] fn,
    input logic       alt
  );
    alu_op_e op;
    unique case (fn)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec      = '0;
    imm      = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    unique case (1'b1)
      (opc == OP_LUI): begin
        uses_rs1      = 1'b0;
        imm           = imm_u;
        dec.src_b     = 1'b1;
        dec.alu_op    = ALU_LUI;
        dec.reg_write = 1'b1;
      end
      (opc == OP_AUIPC): begin
        uses_rs1      = 1'b0;
        imm           = imm_u;
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        dec.reg_write = 1'b1;
      end
      (opc == OP_JAL): begin
        uses_rs1      = 1'b0;
        imm           = imm_j;
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = WB_PC4;
      end
      (opc == OP_JALR): begin
        imm           = imm_i;
        dec.src_b     = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = WB_PC4;
      end
      (opc == OP_BR): begin
        uses_rs2   = 1'b1;
        imm        = imm_b;
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      (opc == OP_LOAD): begin
        imm           = imm_i;
        dec.src_b     = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = WB_MEM;
      end
      (opc == OP_STORE): begin
        uses_rs2      = 1'b1;
        imm           = imm_s;
        dec.src_b     = 1'b1;
        dec.mem_write = 1'b1;
      end
      (opc == OP_IMM): begin
        imm           = imm_i;
        dec.src_b     = 1'b1;
        dec.reg_write = 1'b1;
        // only shifts use bit 30 as a variant
        dec.alu_op    = alu_sel(f3,
          f3 == 3'b101 && instruction_i[30]);
      end
      (opc == OP_REG): begin
        uses_rs2      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_sel(f3,
                                instruction_i[30]);
      end
      default: ;
    endcase
    dec.valid    = 1'b1;
    dec.pc       = pc_i;
    dec.imm      = DATA_WIDTH'($signed(imm));
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.funct3   = f3;
  end

  assign hazard = ex_q.valid & ex_q.mem_read &
                  (ex_q.rd != '0) & if_valid_i &
                  ((uses_rs1 & (rs1 == ex_q.rd)) |
                   (uses_rs2 & (rs2 == ex_q.rd)));

  // A flush overrides any reason to hold IF/ID.
  assign id_ready_o = flush_i |
                      (~stall_i & ~hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ex_q <= '0;
    else if (flush_i)
      ex_q <= '0;
    else if (stall_i)
      ex_q <= ex_q;
    else if (hazard || !if_valid_i)
      ex_q <= '0;
    else
      ex_q <= dec;
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_pc_o        = ex_q.pc;
  assign ex_immediate_o = ex_q.imm;
  assign ex_rd_data1_o  = ex_q.rs1_data;
  assign ex_rd_data2_o  = ex_q.rs2_data;
  assign ex_rs1_addr_o  = ex_q.rs1;
  assign ex_rs2_addr_o  = ex_q.rs2;
  assign ex_rd_addr_o   = ex_q.rd;
  assign ex_funct3_o    = ex_q.funct3;
  assign ex_ALUSrcA_o   = ex_q.src_a;
  assign ex_ALUSrcB_o   = ex_q.src_b;
  assign ex_Branch_o    = ex_q.branch;
  assign ex_Jump_o      = ex_q.jump;
  assign ex_MemWrite_o  = ex_q.mem_write;
  assign ex_MemRead_o   = ex_q.mem_read;
  assign ex_RegWrite_o  = ex_q.reg_write;
  assign ex_ALUOp_o     = ex_q.alu_op;
  assign ex_WBSel_o     = ex_q.wb_sel;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Scoreboard bench for id_ex_decode_stage: one
// bypassing instance and one without bypass.
module tb_id_ex_decode_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] instr, pc, wd;
  logic        stall, flush, we;
  logic [4:0]  wa;

  logic        a_ready, a_valid;
  logic [31:0] a_pc, a_imm, a_d1, a_d2;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_f3;
  logic        a_sa, a_sb, a_br, a_jp;
  logic        a_mw, a_mr, a_rw;
  alu_op_e     a_alu;
  wb_sel_e     a_wb;

  logic        b_ready, b_valid;
  logic [31:0] b_pc, b_imm, b_d1, b_d2;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_f3;
  logic        b_sa, b_sb, b_br, b_jp;
  logic        b_mw, b_mr, b_rw;
  alu_op_e     b_alu;
  wb_sel_e     b_wb;

  always #5 clk = ~clk;

  id_ex_decode_stage #(.BYPASS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid),
    .instruction_i(instr), .pc_i(pc),
    .stall_i(stall), .flush_i(flush),
    .WB_RegWrite_i(we), .wr_addr_i(wa),
    .wr_data_i(wd),
    .id_ready_o(a_ready), .ex_valid_o(a_valid),
    .ex_pc_o(a_pc), .ex_immediate_o(a_imm),
    .ex_rd_data1_o(a_d1), .ex_rd_data2_o(a_d2),
    .ex_rs1_addr_o(a_rs1), .ex_rs2_addr_o(a_rs2),
    .ex_rd_addr_o(a_rd), .ex_funct3_o(a_f3),
    .ex_ALUSrcA_o(a_sa), .ex_ALUSrcB_o(a_sb),
    .ex_Branch_o(a_br), .ex_Jump_o(a_jp),
    .ex_MemWrite_o(a_mw), .ex_MemRead_o(a_mr),
    .ex_RegWrite_o(a_rw), .ex_ALUOp_o(a_alu),
    .ex_WBSel_o(a_wb)
  );

  id_ex_decode_stage #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid),
    .instruction_i(instr), .pc_i(pc),
    .stall_i(stall), .flush_i(flush),
    .WB_RegWrite_i(we), .wr_addr_i(wa),
    .wr_data_i(wd),
    .id_ready_o(b_ready), .ex_valid_o(b_valid),
    .ex_pc_o(b_pc), .ex_immediate_o(b_imm),
    .ex_rd_data1_o(b_d1), .ex_rd_data2_o(b_d2),
    .ex_rs1_addr_o(b_rs1), .ex_rs2_addr_o(b_rs2),
    .ex_rd_addr_o(b_rd), .ex_funct3_o(b_f3),
    .ex_ALUSrcA_o(b_sa), .ex_ALUSrcB_o(b_sb),
    .ex_Branch_o(b_br), .ex_Jump_o(b_jp),
    .ex_MemWrite_o(b_mw), .ex_MemRead_o(b_mr),
    .ex_RegWrite_o(b_rw), .ex_ALUOp_o(b_alu),
    .ex_WBSel_o(b_wb)
  );

  typedef struct {
    int          tag;
    logic        v, ops, nb;
    logic [31:0] pc, imm, d1, d2, d1nb;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  ctl;
  } exp_t;

  localparam logic [4:0] RW = 5'b10000;
  localparam logic [4:0] MR = 5'b01000;
  localparam logic [4:0] JP = 5'b00001;

  localparam logic [31:0] ADDI6 = 32'h00128313;
  localparam logic [31:0] ADD87 = 32'h00038433;
  localparam logic [31:0] ADDA0 = 32'h00000533;
  localparam logic [31:0] ADDA9 = 32'h00248533;
  localparam logic [31:0] LW9   = 32'h0000A483;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] LUI9  = 32'h000484B7;
  localparam logic [31:0] JAL1  = 32'h000480EF;

  exp_t sb[$];
  exp_t m;
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input int tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s tag=%0d got=%h want=%h",
                  nm, tag, act, exp);
  endtask

  task automatic push_bub(input int tag);
    exp_t e;
    e = '{default: '0};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_ins(
    input int tag, input logic [31:0] p, im,
    input logic [31:0] d1, d2,
    input logic [4:0] rd, input logic [2:0] f3,
    input logic [4:0] ctl, input logic ops, nb,
    input logic [31:0] d1nb);
    exp_t e;
    e.tag = tag; e.v = 1'b1;
    e.pc = p; e.imm = im; e.d1 = d1; e.d2 = d2;
    e.rd = rd; e.f3 = f3; e.ctl = ctl;
    e.ops = ops; e.nb = nb; e.d1nb = d1nb;
    sb.push_back(e);
  endtask

  task automatic cyc(
    input logic v, input logic [31:0] ins, p,
    input logic st, fl, w,
    input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    if_valid = v; instr = ins; pc = p;
    stall = st; flush = fl;
    we = w; wa = a; wd = d;
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      m = sb.pop_front();
      chk("valid", m.tag, a_valid, m.v);
      chk("regwrite", m.tag, a_rw, m.ctl[4]);
      chk("memread", m.tag, a_mr, m.ctl[3]);
      chk("memwrite", m.tag, a_mw, m.ctl[2]);
      chk("branch", m.tag, a_br, m.ctl[1]);
      chk("jump", m.tag, a_jp, m.ctl[0]);
      if (m.v) begin
        chk("pc", m.tag, a_pc, m.pc);
        chk("imm", m.tag, a_imm, m.imm);
        chk("rd", m.tag, a_rd, m.rd);
        chk("funct3", m.tag, a_f3, m.f3);
      end
      if (m.v && m.ops) begin
        chk("data1", m.tag, a_d1, m.d1);
        chk("data2", m.tag, a_d2, m.d2);
      end
      if (m.v && m.nb)
        chk("data1_nobyp", m.tag, b_d1, m.d1nb);
    end
  end

  initial begin
    rst_n = 1'b0;
    if_valid = 0; instr = 0; pc = 0;
    stall = 0; flush = 0; we = 0; wa = 0; wd = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 0, a_valid, 0);
    chk("rst_pc", 0, a_pc, 0);
    chk("rst_imm", 0, a_imm, 0);
    chk("rst_d1", 0, a_d1, 0);
    chk("rst_rw", 0, a_rw, 0);
    chk("rst_alu", 0, 32'(a_alu), 0);
    chk("rst_wb", 0, 32'(a_wb), 0);
    chk("rst_ready", 0, a_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    cyc(1, ADDI6, 32'h100, 0, 0, 0, 0, 0);
    chk("ready", 1, a_ready, 1);
    push_ins(1, 32'h100, 1, 0, 0, 6, 0, RW,
             1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 5, 32'hAA);
    push_bub(2);
    cyc(1, ADDI6, 32'h104, 0, 0, 0, 0, 0);
    push_ins(3, 32'h104, 1, 32'hAA, 0, 6, 0, RW,
             1, 1, 32'hAA);
    cyc(1, ADD87, 32'h108, 0, 0, 1, 7, 32'h1234);
    push_ins(4, 32'h108, 0, 32'h1234, 0, 8, 0, RW,
             1, 1, 0);
    cyc(1, ADD87, 32'h10C, 0, 0, 0, 0, 0);
    push_ins(5, 32'h10C, 0, 32'h1234, 0, 8, 0, RW,
             1, 1, 32'h1234);
    cyc(1, ADDA0, 32'h110, 0, 0, 1, 0, 32'hFFFF);
    push_ins(6, 32'h110, 0, 0, 0, 10, 0, RW,
             1, 1, 0);

    cyc(1, LW9, 32'h114, 0, 0, 1, 2, 32'h22);
    chk("ready", 7, a_ready, 1);
    push_ins(7, 32'h114, 0, 0, 0, 9, 2, RW | MR,
             1, 1, 0);
    cyc(1, ADDA9, 32'h118, 0, 0, 1, 9, 32'h99);
    chk("ready_hazard", 8, a_ready, 0);
    push_bub(8);
    cyc(1, ADDA9, 32'h118, 0, 0, 0, 0, 0);
    chk("ready", 9, a_ready, 1);
    push_ins(9, 32'h118, 0, 32'h99, 32'h22, 10, 0,
             RW, 1, 1, 32'h99);

    cyc(1, LW0, 32'h11C, 0, 0, 0, 0, 0);
    push_ins(10, 32'h11C, 0, 0, 0, 0, 2, RW | MR,
             1, 1, 0);
    cyc(1, ADDA0, 32'h120, 0, 0, 0, 0, 0);
    chk("ready_x0", 11, a_ready, 1);
    push_ins(11, 32'h120, 0, 0, 0, 10, 0, RW,
             1, 1, 0);

    cyc(1, LW9, 32'h124, 0, 0, 0, 0, 0);
    push_ins(12, 32'h124, 0, 0, 0, 9, 2, RW | MR,
             1, 1, 0);
    cyc(1, LUI9, 32'h128, 0, 0, 0, 0, 0);
    chk("ready_lui", 13, a_ready, 1);
    push_ins(13, 32'h128, 32'h48000, 0, 0, 9, 0,
             RW, 0, 0, 0);
    cyc(1, LW9, 32'h12C, 0, 0, 0, 0, 0);
    push_ins(14, 32'h12C, 0, 0, 0, 9, 2, RW | MR,
             1, 1, 0);
    cyc(1, JAL1, 32'h130, 0, 0, 0, 0, 0);
    chk("ready_jal", 15, a_ready, 1);
    push_ins(15, 32'h130, 32'h48000, 0, 0, 1, 0,
             RW | JP, 0, 0, 0);

    cyc(1, ADD87, 32'h140, 0, 0, 0, 0, 0);
    push_ins(16, 32'h140, 0, 32'h1234, 0, 8, 0, RW,
             1, 1, 32'h1234);
    for (int i = 17; i < 20; i++) begin
      cyc(1, ADDI6, 32'h144, 1, 0, 0, 0, 0);
      chk("ready_stall", i, a_ready, 0);
      push_ins(i, 32'h140, 0, 32'h1234, 0, 8, 0,
               RW, 1, 1, 32'h1234);
    end
    cyc(1, ADDI6, 32'h144, 0, 0, 0, 0, 0);
    chk("ready", 20, a_ready, 1);
    push_ins(20, 32'h144, 1, 32'hAA, 0, 6, 0, RW,
             1, 1, 32'hAA);

    cyc(1, LW9, 32'h148, 0, 0, 0, 0, 0);
    push_ins(21, 32'h148, 0, 0, 0, 9, 2, RW | MR,
             1, 1, 0);
    cyc(1, ADDA9, 32'h14C, 1, 1, 0, 0, 0);
    chk("ready_flush", 22, a_ready, 1);
    push_bub(22);
    cyc(1, ADDA9, 32'h14C, 0, 0, 0, 0, 0);
    chk("ready", 23, a_ready, 1);
    push_ins(23, 32'h14C, 0, 32'h99, 32'h22, 10, 0,
             RW, 1, 1, 32'h99);

    cyc(1, ADDI6, 32'h150, 0, 0, 0, 0, 0);
    push_ins(24, 32'h150, 1, 32'hAA, 0, 6, 0, RW,
             1, 1, 32'hAA);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 24, a_valid, 0);
    chk("arst_rw", 24, a_rw, 0);
    chk("arst_d1", 24, a_d1, 0);
    chk("arst_rd", 24, a_rd, 0);
    chk("arst_pc", 24, a_pc, 0);
    chk("arst_ready", 24, a_ready, 1);
    @(negedge clk);
    if_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    cyc(1, ADDI6, 32'h160, 0, 0, 0, 0, 0);
    push_ins(25, 32'h160, 1, 0, 0, 6, 0, RW,
             1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 0, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
